// File: rtl/freq_meter.sv
// Measures the period and high time of an asynchronous input in system-clock cycles.
// Optional FREQ_METER_CONTINUOUS_EN: keep measuring every input period instead of single-shot.
module freq_meter #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in,
  input  logic             start,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             valid,
  output logic             busy,
  output logic             timeout,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state;
  state_t           state_nxt;
  logic             sync_a;
  logic             sync_b;
  logic             sync_d;
  logic             rise;
  logic             sat;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] hcnt;
  logic [CNT_W-1:0] hcnt_nxt;
  logic             load;
  logic             timeout_nxt;

  // sync_d holds the previous synchronized sample for edge detection.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_a <= 1'b0;
      sync_b <= 1'b0;
      sync_d <= 1'b0;
    end else begin
      sync_a <= in;
      sync_b <= sync_a;
      sync_d <= sync_b;
    end
  end

  assign rise = sync_b & ~sync_d;
  assign sat  = (cnt == CNT_MAX);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
      hcnt  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      hcnt  <= hcnt_nxt;
    end
  end

  // A rise always beats saturation, so a period of exactly CNT_MAX is still reported.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    hcnt_nxt    = hcnt;
    load        = 1'b0;
    timeout_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = ARM;
          cnt_nxt   = '0;
          hcnt_nxt  = '0;
        end
      end
      ARM: begin
        if (rise) begin
          state_nxt = MEASURE;
          cnt_nxt   = CNT_ONE;
          hcnt_nxt  = CNT_ONE;
        end else if (sat) begin
          state_nxt   = IDLE;
          timeout_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      MEASURE: begin
        if (rise) begin
          load = 1'b1;
`ifdef FREQ_METER_CONTINUOUS_EN
          cnt_nxt  = CNT_ONE;
          hcnt_nxt = CNT_ONE;
`else
          state_nxt = IDLE;
`endif
        end else if (sat) begin
          state_nxt   = IDLE;
          timeout_nxt = 1'b1;
        end else begin
          cnt_nxt  = cnt + CNT_ONE;
          hcnt_nxt = hcnt + {{(CNT_W-1){1'b0}}, sync_b};
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      period    <= '0;
      high_time <= '0;
      valid     <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      valid   <= load;
      timeout <= timeout_nxt;
      if (load) begin
        period    <= cnt;
        high_time <= hcnt;
      end
    end
  end

  assign busy      = (state != IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_freq_meter.sv
// Randomized scoreboard bench for freq_meter: expected events come from a waveform-level model.
module tb_freq_meter;

  localparam int CNT_W = 5;
  localparam int MAX   = (1 << CNT_W) - 1;
  localparam int EW    = 2 + 2 * CNT_W + 32;

  logic             clock = 1'b0;
  logic             reset_n = 1'b0;
  logic             in = 1'b0;
  logic             start = 1'b0;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             valid;
  logic             busy;
  logic             timeout;
  logic [1:0]       dbg_state;

  freq_meter #(.CNT_W(CNT_W)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in        (in),
    .start     (start),
    .period    (period),
    .high_time (high_time),
    .valid     (valid),
    .busy      (busy),
    .timeout   (timeout),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- scoreboard ----------------
  // entry = {is_timeout, busy, period, high_time, visible_cycle}
  logic [EW-1:0] exp_q[$];
  int last_per = 0;
  int last_hi  = 0;

  function automatic void push_ev(input bit is_to, input bit bsy, input int per,
                                  input int hi, input int at);
    logic [EW-1:0] e;
    e = {is_to, bsy, per[CNT_W-1:0], hi[CNT_W-1:0], at[31:0]};
    exp_q.push_back(e);
  endfunction

  always @(negedge clock) begin
    logic [EW-1:0] e;
    if (reset_n && (valid || timeout)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_event", int'({valid, timeout}), 0);
      end else begin
        e = exp_q.pop_front();
        check("event_cycle", cyc, int'(e[31:0]));
        check("timeout_flag", int'(timeout), int'(e[EW-1]));
        check("valid_flag", int'(valid), int'(!e[EW-1]));
        check("busy_at_event", int'(busy), int'(e[EW-2]));
        check("period", int'(period), int'(e[EW-3 -: CNT_W]));
        check("high_time", int'(high_time), int'(e[32+CNT_W-1 -: CNT_W]));
      end
    end
  end

  // ---------------- reference model ----------------
  // Works on the whole stimulus: synchronized input is in delayed two cycles,
  // results are derived from the list of rising-edge cycles after an accepted start.
  bit wave[256];
  bit stv[256];

  task automatic model_scn(input int base, input int len);
    bit s[256];
    bit rise[256];
    int c, pos, r0, r1, hi;
    bit measuring;
    for (int k = 0; k < len; k++) begin
      s[k]    = (k >= 2) ? wave[k-2] : 1'b0;
      rise[k] = s[k] && !((k > 0) ? s[k-1] : 1'b0);
    end
    c = 0;
    while (c < len) begin
      if (!stv[c]) begin
        c++;
        continue;
      end
      pos = c;
      r0 = -1;
      for (int k = pos + 1; k <= pos + 1 + MAX && k < len; k++)
        if (rise[k] && r0 < 0) r0 = k;
      if (r0 < 0) begin
        if (pos + MAX + 2 < len) push_ev(1'b1, 1'b0, last_per, last_hi, base + pos + MAX + 2);
        c = pos + MAX + 2;
        continue;
      end
      measuring = 1'b1;
      while (measuring) begin
        r1 = -1;
        for (int k = r0 + 1; k <= r0 + MAX && k < len; k++)
          if (rise[k] && r1 < 0) r1 = k;
        if (r1 < 0) begin
          if (r0 + MAX + 1 < len) push_ev(1'b1, 1'b0, last_per, last_hi, base + r0 + MAX + 1);
          c = r0 + MAX + 1;
          measuring = 1'b0;
        end else begin
          hi = 0;
          for (int k = r0; k < r1; k++) hi += int'(s[k]);
          last_per = r1 - r0;
          last_hi  = hi;
`ifdef FREQ_METER_CONTINUOUS_EN
          push_ev(1'b0, 1'b1, last_per, last_hi, base + r1 + 1);
          r0 = r1;
`else
          push_ev(1'b0, 1'b0, last_per, last_hi, base + r1 + 1);
          c = r1 + 1;
          measuring = 1'b0;
`endif
        end
      end
    end
  endtask

  // ---------------- drivers ----------------
  task automatic clr_scn();
    for (int k = 0; k < 256; k++) begin
      wave[k] = 1'b0;
      stv[k]  = 1'b0;
    end
  endtask

  task automatic gen_periodic(input int lead, input int p, input int h, input int nper);
    for (int k = 0; k < nper * p; k++) wave[lead + k] = ((k % p) < h);
  endtask

  task automatic run_scn(input int len);
    int base;
    @(posedge clock); #1;
    base = cyc;
    model_scn(base, len);
    for (int i = 0; i < len; i++) begin
      in    = wave[i];
      start = stv[i];
      @(posedge clock); #1;
    end
    in    = 1'b0;
    start = 1'b0;
    check("idle_after_scenario", int'(busy), 0);
    check("pending_events", exp_q.size(), 0);
  endtask

  task automatic periodic_scn(input int lead, input int p, input int h, input int nper,
                              input int st);
    clr_scn();
    gen_periodic(lead, p, h, nper);
    stv[st] = 1'b1;
    run_scn(lead + nper * p + MAX + 6);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock); #1;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int p, h;
    idle_cycles(2);
    @(negedge clock);
    check("rst_period", int'(period), 0);
    check("rst_high_time", int'(high_time), 0);
    check("rst_valid", int'(valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_timeout", int'(timeout), 0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    idle_cycles(4);

    // 9-cycle input, 5 high / 4 low
    periodic_scn(3, 9, 5, 3, 0);

    // start coincident with a rise, extra starts while in ARM and in MEASURE
    clr_scn();
    gen_periodic(3, 7, 3, 3);
    stv[5]  = 1'b1;
    stv[6]  = 1'b1;
    stv[13] = 1'b1;
    run_scn(3 + 21 + MAX + 6);

    // fastest legal input
    periodic_scn(2, 2, 1, 4, 0);

    // period exactly at counter saturation: the rise wins
    periodic_scn(2, MAX, $urandom_range(1, MAX - 1), 2, 0);

    // single pulse then silence: timeout in MEASURE keeps last results
    clr_scn();
    wave[2] = 1'b1;
    wave[3] = 1'b1;
    wave[4] = 1'b1;
    stv[0]  = 1'b1;
    run_scn(2 + 3 + MAX + 6);

    for (int n = 0; n < 8; n++) begin
      p = $urandom_range(2, 14);
      h = $urandom_range(1, p - 1);
      periodic_scn($urandom_range(2, 5), p, h, $urandom_range(3, 4), $urandom_range(0, p + 2));
    end

    // reset in the middle of a measurement
    clr_scn();
    gen_periodic(2, 6, 3, 6);
    stv[0] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in    = wave[i];
      start = stv[i];
      @(posedge clock); #1;
    end
    check("busy_before_reset", int'(busy), 1);
    reset_n = 1'b0;
    #1;
    check("abort_period", int'(period), 0);
    check("abort_high_time", int'(high_time), 0);
    check("abort_valid", int'(valid), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_timeout", int'(timeout), 0);
    last_per = 0;
    last_hi  = 0;
    in = 1'b0;
    idle_cycles(3);
    reset_n = 1'b1;

    // no start after reset: toggling input must not produce results
    clr_scn();
    gen_periodic(0, 5, 2, 4);
    for (int i = 0; i < 20; i++) begin
      in = wave[i];
      @(posedge clock); #1;
    end
    in = 1'b0;
    idle_cycles(4);
    check("busy_without_start", int'(busy), 0);

    // input held low: timeout in ARM with zero results
    clr_scn();
    stv[0] = 1'b1;
    run_scn(MAX + 8);

    // fresh measurement after the abort
    periodic_scn(3, 6, 2, 3, 1);

    idle_cycles(2);
    check("final_queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
